// File: rtl/subleq_core.sv
// SUBLEQ instruction sequencer. It walks each instruction through fetch,
// operand load, store and branch, issuing one request/wait handshake per
// memory access on the FRAM word-interface request port.
module subleq_core #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] OUT_ADDR  = 16'hFFFE,
  parameter logic [15:0] HALT_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_start,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        halted,
  output logic [15:0] pc_dbg
);

  localparam logic [2:0] S_FETCH_A = 3'd0;
  localparam logic [2:0] S_FETCH_B = 3'd1;
  localparam logic [2:0] S_FETCH_C = 3'd2;
  localparam logic [2:0] S_LOAD_A  = 3'd3;
  localparam logic [2:0] S_LOAD_B  = 3'd4;
  localparam logic [2:0] S_STORE   = 3'd5;
  localparam logic [2:0] S_BRANCH  = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  logic [2:0]  state;
  logic        wait_ph;   // 0 = request phase, 1 = waiting for mem_done
  logic [15:0] pc;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] op_c;
  logic [15:0] va;
  logic [15:0] vb;
  logic [15:0] res;
  logic [15:0] rd_addr;
  logic [15:0] diff;
  logic        out_store;
  logic        taken;

  assign pc_dbg    = pc;
  assign diff      = vb - va;
  assign out_store = (op_b == OUT_ADDR);
  assign taken     = res[15] | (res == 16'h0000);

  // Read address for each of the read-access states.
  always_comb begin
    rd_addr = pc;
    case (state)
      S_FETCH_B: rd_addr = pc + 16'd1;
      S_FETCH_C: rd_addr = pc + 16'd2;
      S_LOAD_A:  rd_addr = op_a;
      S_LOAD_B:  rd_addr = op_b;
      default:   rd_addr = pc;
    endcase
  end

  // Instruction sequencer: request/wait handshake per access, then branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH_A;
      wait_ph   <= 1'b0;
      pc        <= RESET_PC;
      op_a      <= 16'h0000;
      op_b      <= 16'h0000;
      op_c      <= 16'h0000;
      va        <= 16'h0000;
      vb        <= 16'h0000;
      res       <= 16'h0000;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      mem_we    <= 1'b0;
      mem_start <= 1'b0;
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      mem_start <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        S_FETCH_A, S_FETCH_B, S_FETCH_C, S_LOAD_A, S_LOAD_B: begin
          if (!wait_ph) begin
            // run only gates the start of a new instruction
            if (state != S_FETCH_A || run) begin
              mem_addr  <= rd_addr;
              mem_we    <= 1'b0;
              mem_start <= 1'b1;
              wait_ph   <= 1'b1;
            end
          end else if (mem_done) begin
            wait_ph <= 1'b0;
            case (state)
              S_FETCH_A: begin
                op_a  <= mem_rdata;
                state <= S_FETCH_B;
              end
              S_FETCH_B: begin
                op_b  <= mem_rdata;
                state <= S_FETCH_C;
              end
              S_FETCH_C: begin
                op_c  <= mem_rdata;
                state <= S_LOAD_A;
              end
              S_LOAD_A: begin
                va <= mem_rdata;
                if (out_store) begin
                  // output store never reads its b operand
                  vb    <= 16'h0000;
                  state <= S_STORE;
                end else begin
                  state <= S_LOAD_B;
                end
              end
              default: begin
                vb    <= mem_rdata;
                state <= S_STORE;
              end
            endcase
          end
        end
        S_STORE: begin
          if (!wait_ph) begin
            res <= diff;
            if (out_store) begin
              out_data  <= diff;
              out_valid <= 1'b1;
              state     <= S_BRANCH;
            end else begin
              mem_addr  <= op_b;
              mem_wdata <= diff;
              mem_we    <= 1'b1;
              mem_start <= 1'b1;
              wait_ph   <= 1'b1;
            end
          end else if (mem_done) begin
            wait_ph <= 1'b0;
            state   <= S_BRANCH;
          end
        end
        S_BRANCH: begin
          if (taken) begin
            pc <= op_c;
            if (op_c == HALT_ADDR) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH_A;
            end
          end else begin
            pc    <= pc + 16'd3;
            state <= S_FETCH_A;
          end
        end
        default: begin
          // halted: no further accesses until reset
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/subleq_core.md
Name: subleq_core

Overview:
- Instruction sequencer for the SUBLEQ CPU. Sits directly upstream of the SPI FRAM word interface and drives its addr/data_in/we/start request port, consuming data_out/done.
- Executes SUBLEQ a,b,c on 16-bit words: mem[b] := mem[b] - mem[a]; if the result is <= 0 (signed), jump to c, else pc := pc+3.
- Provides a memory-mapped output word and a halt address.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- OUT_ADDR, 16'hFFFE, a b operand equal to this redirects the store to out_data instead of memory.
- HALT_ADDR, 16'hFFFF, a taken branch to this address halts the core.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  execution enable, sampled only at instruction boundary
- mem_addr  output  16  word address to FRAM interface
- mem_wdata  output  16  write data to FRAM interface
- mem_we  output  1  1=write, 0=read; qualifies mem_start
- mem_start  output  1  one-cycle request pulse
- mem_rdata  input  16  read word from FRAM interface
- mem_done  input  1  one-cycle completion pulse from FRAM interface
- out_data  output  16  last value written to OUT_ADDR
- out_valid  output  1  one-cycle pulse when out_data updates
- halted  output  1  sticky halt flag
- pc_dbg  output  16  current instruction PC

Behaviour:
- Reset (rst=1 at a clock edge) values: pc=RESET_PC, state=FETCH_A (request phase), mem_start=0, mem_we=0, mem_addr=0, mem_wdata=0, out_data=0, out_valid=0, halted=0. Reset mid-transaction abandons the access; the FRAM interface is reset by the same system reset.
- States: FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, STORE, BRANCH, HALT.
- Access states have two phases, REQ and WAIT:
  - REQ: drive mem_addr/mem_we/mem_wdata and assert mem_start for exactly one cycle.
  - WAIT: hold mem_addr/mem_we/mem_wdata stable and mem_start=0 until mem_done=1.
  - mem_done is ignored outside WAIT. It is never issued back-to-back: the next REQ is at least 1 cycle after done.
- FETCH_A reads pc -> A. FETCH_B reads pc+1 -> B. FETCH_C reads pc+2 -> C. LOAD_A reads A -> va.
- LOAD_B reads B -> vb. If B==OUT_ADDR, LOAD_B is skipped (no access) and vb=0.
- STORE:
  - res = vb - va, modulo 2^16.
  - If B!=OUT_ADDR: write res to B (mem_we=1).
  - If B==OUT_ADDR: no access; out_data<=res and out_valid=1 for one cycle.
- BRANCH (1 cycle, no access):
  - Taken iff res[15]==1 or res==0.
  - Taken: pc<=C. If C==HALT_ADDR, go to HALT.
  - Not taken: pc<=pc+3, wrapping modulo 2^16.
  - Otherwise go to FETCH_A.
- PC offset arithmetic (pc+1, pc+2, pc+3) wraps modulo 2^16.
- run: checked only on entry to FETCH_A REQ. If run=0, stall there with no mem_start until run=1. Deasserting run mid-instruction does not interrupt the instruction.
- HALT: halted=1, no further mem_start, pc_dbg holds C. Exit only by rst.
- pc_dbg equals pc throughout; it updates in BRANCH.
- Access counts: normal instruction = 6 mem_start pulses (5 reads + 1 write). Output instruction = 4 pulses (reads only).

Test Plan:
- Reset/first fetch, memory model done latency 5 cycles: release rst with run=1 -> first mem_start has addr=0x0000, we=0; second has addr=0x0001 one cycle after done at the earliest.
- mem[0..2]={10,11,30}, mem[10]=5, mem[11]=7 -> write pulse addr=11, wdata=0x0002, we=1; next fetch at addr 0x0003; pc_dbg=3; exactly 6 mem_start pulses.
- Same program with mem[10]=7, mem[11]=7 -> write wdata=0x0000; branch taken, next fetch at addr 30. With mem[10]=1, mem[11]=0x8000 -> wdata=0x7FFF, not taken, next fetch at 3.
- Output: mem[0..2]={10,0xFFFE,3}, mem[10]=0xFFBF -> no write; out_data=0x0041 with a single out_valid pulse; 4 mem_start pulses; next fetch at 3.
- Halt and run: mem[0..2]={10,10,0xFFFF} -> writes 0 to addr 10, halted=1, no mem_start for 100 cycles, pc_dbg=0xFFFF. Separately, with run=0 from reset -> no mem_start; raising run -> fetch at 0.
- Reset mid-WAIT of LOAD_B: assert rst for 1 cycle -> mem_start=0 and outputs at reset values; refetch begins at RESET_PC.
